multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control unit for the multicycle RV32I core. It sequences the shared datapath (single memory, single ALU) through per-instruction state sequences and decodes op/funct fields into ALU, immediate and mux selects. It sits in the core between the instruction register and the datapath, and replaces the combinational single-cycle decoder.

Parameters:
STATE_W, 4, width of the StateDbg debug output (must be ≥4)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
op  in  7  instruction opcode, Instr[6:0]
funct3  in  3  Instr[14:12]
funct7b5  in  1  Instr[30]
Zero  in  1  ALU zero flag
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select (0 = PC, 1 = Result)
MemWrite  out  1  data memory write strobe
IRWrite  out  1  instruction/OldPC register enable
ResultSrc  out  2  result mux select (00 ALUOut, 01 Data, 10 ALUResult)
ALUSrcA  out  2  ALU A select (00 PC, 01 OldPC, 10 rs1)
ALUSrcB  out  2  ALU B select (00 rs2, 01 ImmExt, 10 constant 4)
ALUControl  out  3  ALU operation code
ImmSrc  out  2  immediate format (00 I, 01 S, 10 B, 11 J)
RegWrite  out  1  register file write enable
InstrDone  out  1  one-cycle pulse in the final state of every instruction
Illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode
StateDbg  out  STATE_W  current state encoding

Behaviour:
- Moore FSM, 4-bit state register. Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. Codes 11–15 go to FETCH on the next edge.
- Reset: when reset==0 at a rising edge, state becomes FETCH. While reset==0, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 combinationally, and InstrDone and Illegal are 0. This holds even mid-instruction.
- Transitions:
  - FETCH→DECODE.
  - DECODE: op 0000011 or 0100011→MEMADR; 0110011→EXECUTER; 0010011→EXECUTEI; 1100011→BEQ; 1101111→JAL; any other op→FETCH with Illegal=1.
  - MEMADR: op[5]=0→MEMREAD, else→MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER, EXECUTEI and JAL→ALUWB→FETCH.
  - BEQ→FETCH.
- Per-state outputs (unlisted outputs are 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, PCUpdate=1.
- PCWrite = PCUpdate | (Branch & Zero).
- InstrDone=1 in MEMWB, MEMWRITE, ALUWB and BEQ.
- Cycle counts, FETCH to FETCH: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3, illegal 2.
- ALU decoder:
  - ALUOp 00→000 (add); ALUOp 01→001 (sub).
  - ALUOp 10, by funct3: 000→001 if (op[5] & funct7b5), else 000; 010→101 (slt); 110→011 (or); 111→010 (and); any other funct3→000.
  - ALUOp 11→000.
- ImmSrc (combinational on op, valid in every state): 0100011→01; 1100011→10; 1101111→11; all others→00.
- Internal signals (ALUOp, Branch, PCUpdate) are not ports.

Optional Feature:
MULTICYCLE_CTRL_MEM_WAIT_EN
- Defined: adds input MemReady (1 bit).
  - FETCH, MEMREAD and MEMWRITE hold state while MemReady==0.
  - In FETCH, IRWrite and PCUpdate are gated by MemReady.
  - In MEMWRITE, MemWrite stays 1 until the cycle in which MemReady==1.
  - InstrDone in MEMWRITE fires only when MemReady==1.
- Undefined: no MemReady port; memory is treated as always ready, with cycle counts exactly as above.

Test Plan:
- Release reset, op=0000011 (lw) held → states 0,1,2,3,4,0. IRWrite=1 only in state 0, RegWrite=1 only in state 4, ResultSrc=01 in state 4, InstrDone pulses once.
- op=0100011 (sw) → states 0,1,2,5,0. MemWrite=1 only in state 5 with AdrSrc=1, ImmSrc=01 throughout.
- op=0110011, funct3=000, funct7b5=1 → ALUControl=001 in EXECUTER. Repeat with op=0010011, funct7b5=1 → ALUControl=000 in EXECUTEI. funct3=110 → 011.
- op=1100011: Zero=1 → PCWrite=1 in BEQ and ALUControl=001; Zero=0 → PCWrite=0. Both return to FETCH after 3 cycles.
- op=0000000 → states 0,1,0, Illegal=1 for exactly the DECODE cycle, no RegWrite or MemWrite.
- sw in MEMWRITE, drive reset=0 for one cycle → MemWrite=0 in that same cycle, state=FETCH after the edge. With the MEM_WAIT_EN macro defined, holding MemReady=0 for 3 cycles in MEMWRITE keeps MemWrite=1 for 4 cycles.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// ==========================================================================
// multicycle_ctrl : RV32I multicycle main control FSM and ALU/immediate decode
// Option macro    : MULTICYCLE_CTRL_MEM_WAIT_EN (adds MemReady memory stall)
// Revision        : 1.0
// ==========================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  input  logic               MemReady,
`endif
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic               InstrDone,
  output logic               Illegal,
  output logic [STATE_W-1:0] StateDbg
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [3:0] state_q, state_d;
  logic [1:0] w_alu_op;
  logic       w_branch;
  logic       w_pc_update;
  logic       w_mem_ready;
  logic       w_op_legal;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  assign w_mem_ready = MemReady;
`else
  assign w_mem_ready = 1'b1;
`endif

  always_comb begin
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: w_op_legal = 1'b1;
      default:                                                w_op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = w_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = w_mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = w_mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      S_ALUWB, S_BEQ:                state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    InstrDone   = 1'b0;
    Illegal     = 1'b0;
    w_alu_op    = 2'b00;
    w_branch    = 1'b0;
    w_pc_update = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite     = w_mem_ready;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        w_pc_update = w_mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        Illegal = ~w_op_legal;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = w_mem_ready;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA  = 2'b10;
        w_alu_op = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        w_alu_op = 2'b10;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA   = 2'b10;
        w_alu_op  = 2'b01;
        w_branch  = 1'b1;
        InstrDone = 1'b1;
      end
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
      end
      default: ;
    endcase
    // Reset must suppress every architectural write strobe, even mid-instruction
    if (!reset) begin
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      InstrDone   = 1'b0;
      Illegal     = 1'b0;
      w_pc_update = 1'b0;
      w_branch    = 1'b0;
    end
    PCWrite = w_pc_update | (w_branch & Zero);
  end

  always_comb begin
    ALUControl = 3'b000;
    case (w_alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE: ImmSrc = 2'b01;
      OP_BEQ:   ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    StateDbg      = '0;
    StateDbg[3:0] = state_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ==========================================================================
// tb_multicycle_ctrl : directed vector bench for multicycle_ctrl
// Revision           : 1.0
// ==========================================================================
`default_nettype none

module tb_multicycle_ctrl;

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] BQ = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] XX = 7'b0000000;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] StateDbg;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  logic       MemReady;
`endif

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    .MemReady   (MemReady),
`endif
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .InstrDone  (InstrDone),
    .Illegal    (Illegal),
    .StateDbg   (StateDbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic [3:0] st;
    logic       pcw, adr, mw, irw;
    logic [1:0] rs, sa, sb;
    logic [2:0] ac;
    logic [1:0] imm;
    logic       rw, dn, il;
  } vec_t;

  vec_t vecs[$];
  int   n_pass;
  int   n_total;

  task automatic add(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic [3:0] st,
                     input logic pcw, input logic adr, input logic mw, input logic irw,
                     input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                     input logic [2:0] ac, input logic [1:0] imm,
                     input logic rw, input logic dn, input logic il);
    vec_t v;
    v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.st = st;
    v.pcw = pcw; v.adr = adr; v.mw = mw; v.irw = irw;
    v.rs = rs; v.sa = sa; v.sb = sb; v.ac = ac; v.imm = imm;
    v.rw = rw; v.dn = dn; v.il = il;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else
      n_pass++;
  endtask

  // Runs one instruction from FETCH back to FETCH; caller leaves us just after a negedge in FETCH.
  task automatic run_instr(input logic [6:0] o, input int exp_cyc, input int exp_dn,
                           input int exp_il, input string nm);
    int cyc, dn, il;
    op = o; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    chk({nm, "_start_state"}, {28'd0, StateDbg}, 32'd0);
    cyc = 0; dn = 0; il = 0;
    do begin
      #1;
      dn += int'(InstrDone);
      il += int'(Illegal);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (StateDbg != 4'd0 && cyc < 20);
    chk({nm, "_cycles"}, cyc, exp_cyc);
    chk({nm, "_done_ill"}, {dn[15:0], il[15:0]}, {exp_dn[15:0], exp_il[15:0]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b0; op = LW; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    MemReady = 1'b1;
`endif

    //   rst op f3 f7 z   st pcw adr mw irw  rs sa sb ac imm  rw dn il
    add(0, LW, 0, 0, 0,  0, 0, 0, 0, 0,  2, 0, 2, 0, 0,  0, 0, 0);
    add(1, LW, 0, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    add(1, LW, 0, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 0,  0, 0, 0);
    add(1, LW, 0, 0, 0,  2, 0, 0, 0, 0,  0, 2, 1, 0, 0,  0, 0, 0);
    add(1, LW, 0, 0, 0,  3, 0, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
    add(1, LW, 0, 0, 0,  4, 0, 0, 0, 0,  1, 0, 0, 0, 0,  1, 1, 0);
    add(1, SW, 0, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 1,  0, 0, 0);
    add(1, SW, 0, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 1,  0, 0, 0);
    add(1, SW, 0, 0, 0,  2, 0, 0, 0, 0,  0, 2, 1, 0, 1,  0, 0, 0);
    add(1, SW, 0, 0, 0,  5, 0, 1, 1, 0,  0, 0, 0, 0, 1,  0, 1, 0);
    // R-type sub
    add(1, RT, 0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    add(1, RT, 0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 0,  0, 0, 0);
    add(1, RT, 0, 1, 0,  6, 0, 0, 0, 0,  0, 2, 0, 1, 0,  0, 0, 0);
    add(1, RT, 0, 1, 0,  8, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0);
    // addi with funct7b5=1 stays add
    add(1, IT, 0, 1, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    add(1, IT, 0, 1, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 0,  0, 0, 0);
    add(1, IT, 0, 1, 0,  7, 0, 0, 0, 0,  0, 2, 1, 0, 0,  0, 0, 0);
    add(1, IT, 0, 1, 0,  8, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0);
    // ori, slt, andi
    add(1, IT, 6, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    add(1, IT, 6, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 0,  0, 0, 0);
    add(1, IT, 6, 0, 0,  7, 0, 0, 0, 0,  0, 2, 1, 3, 0,  0, 0, 0);
    add(1, IT, 6, 0, 0,  8, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0);
    add(1, RT, 2, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    add(1, RT, 2, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 0,  0, 0, 0);
    add(1, RT, 2, 0, 0,  6, 0, 0, 0, 0,  0, 2, 0, 5, 0,  0, 0, 0);
    add(1, RT, 2, 0, 0,  8, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0);
    add(1, IT, 7, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    add(1, IT, 7, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 0,  0, 0, 0);
    add(1, IT, 7, 0, 0,  7, 0, 0, 0, 0,  0, 2, 1, 2, 0,  0, 0, 0);
    add(1, IT, 7, 0, 0,  8, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0);
    // beq taken, then not taken
    add(1, BQ, 0, 0, 1,  0, 1, 0, 0, 1,  2, 0, 2, 0, 2,  0, 0, 0);
    add(1, BQ, 0, 0, 1,  1, 0, 0, 0, 0,  0, 1, 1, 0, 2,  0, 0, 0);
    add(1, BQ, 0, 0, 1,  9, 1, 0, 0, 0,  0, 2, 0, 1, 2,  0, 1, 0);
    add(1, BQ, 0, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 2,  0, 0, 0);
    add(1, BQ, 0, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 2,  0, 0, 0);
    add(1, BQ, 0, 0, 0,  9, 0, 0, 0, 0,  0, 2, 0, 1, 2,  0, 1, 0);
    // jal
    add(1, JL, 0, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 3,  0, 0, 0);
    add(1, JL, 0, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 3,  0, 0, 0);
    add(1, JL, 0, 0, 0, 10, 1, 0, 0, 0,  0, 1, 2, 0, 3,  0, 0, 0);
    add(1, JL, 0, 0, 0,  8, 0, 0, 0, 0,  0, 0, 0, 0, 3,  1, 1, 0);
    // illegal opcode
    add(1, XX, 0, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    add(1, XX, 0, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 0,  0, 0, 1);
    add(1, XX, 0, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 0,  0, 0, 0);
    // sw interrupted by reset in MEMWRITE
    add(1, SW, 0, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0, 1,  0, 0, 0);
    add(1, SW, 0, 0, 0,  2, 0, 0, 0, 0,  0, 2, 1, 0, 1,  0, 0, 0);
    add(0, SW, 0, 0, 0,  5, 0, 1, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0);
    add(1, SW, 0, 0, 0,  0, 1, 0, 0, 1,  2, 0, 2, 0, 1,  0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset    = vecs[i].rst;
      op       = vecs[i].op;
      funct3   = vecs[i].f3;
      funct7b5 = vecs[i].f7;
      Zero     = vecs[i].z;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {10'd0, StateDbg, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ALUControl, ImmSrc, RegWrite, InstrDone, Illegal},
          {10'd0, vecs[i].st, vecs[i].pcw, vecs[i].adr, vecs[i].mw, vecs[i].irw,
           vecs[i].rs, vecs[i].sa, vecs[i].sb, vecs[i].ac, vecs[i].imm,
           vecs[i].rw, vecs[i].dn, vecs[i].il});
      @(posedge clk);
      #1;
    end

    // Per-instruction cycle counts and pulse counts
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    run_instr(LW, 5, 1, 0, "lw");
    run_instr(SW, 4, 1, 0, "sw");
    run_instr(RT, 4, 1, 0, "rtype");
    run_instr(IT, 4, 1, 0, "itype");
    run_instr(JL, 4, 1, 0, "jal");
    run_instr(BQ, 3, 1, 0, "beq");
    run_instr(XX, 2, 0, 1, "illegal");

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    begin
      int guard, mw_cnt, dn_cnt;
      op = SW;
      guard = 0;
      while (StateDbg != 4'd5 && guard < 10) begin
        @(posedge clk);
        @(negedge clk);
        guard++;
      end
      chk("wait_reach_memwrite", {28'd0, StateDbg}, 32'd5);
      mw_cnt = 0; dn_cnt = 0;
      for (int k = 0; k < 4; k++) begin
        MemReady = (k == 3);
        #1;
        mw_cnt += int'(MemWrite);
        dn_cnt += int'(InstrDone);
        @(posedge clk);
        @(negedge clk);
      end
      chk("wait_memwrite_cycles", mw_cnt, 4);
      chk("wait_done_pulses", dn_cnt, 1);
      chk("wait_back_to_fetch", {28'd0, StateDbg}, 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
